// File: rtl/tpu_out_writer_if.sv
// Port bundle for the GBUFF_OUT write-back stage: tile control, result-row input and buffer write port.
// A row moves on every rising edge where in_valid && in_ready. A write commits on every edge where wr_en && wr_gnt, and wr_addr/wr_data hold until then.
interface tpu_out_writer_if #(
  parameter int LANES  = 5,
  parameter int ACC_W  = 16,
  parameter int ADDR_W = 8
);
  logic                     start;
  logic [3:0]               m;
  logic [3:0]               n;
  logic [3:0]               tile;
  logic [3:0]               n_tiles;
  logic                     in_valid;
  logic                     in_ready;
  logic [LANES*ACC_W-1:0]   in_data;
  logic                     wr_en;
  logic                     wr_gnt;
  logic [ADDR_W-1:0]        wr_addr;
  logic [LANES*8-1:0]       wr_data;
  logic                     busy;
  logic                     done;

  modport master (
    output start, m, n, tile, n_tiles, in_valid, in_data, wr_gnt,
    input  in_ready, wr_en, wr_addr, wr_data, busy, done
  );

  modport slave (
    input  start, m, n, tile, n_tiles, in_valid, in_data, wr_gnt,
    output in_ready, wr_en, wr_addr, wr_data, busy, done
  );
endinterface

// File: rtl/tpu_out_writer.sv
// Output write-back stage: narrows and masks one drained systolic row per handshake into a packed word,
// buffers up to two words and writes them to GBUFF_OUT at row*n_tiles+tile.
module tpu_out_writer #(
  parameter int LANES  = 5,
  parameter int ACC_W  = 16,
  parameter int ADDR_W = 8,
  parameter int SAT    = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  tpu_out_writer_if.slave  bus,
  output logic [1:0]       o_dbg_state
);
  localparam int VL_W   = $clog2(LANES + 1);
  localparam int WORD_W = LANES * 8;
  localparam logic signed [ACC_W-1:0] SMAX = ACC_W'(127);
  localparam logic signed [ACC_W-1:0] SMIN = ACC_W'(-128);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [3:0]              r_m;
  logic [3:0]              r_n_tiles;
  logic [3:0]              r_rows_in;
  logic [VL_W-1:0]         r_valid_lanes;
  logic [ADDR_W-1:0]       r_addr;
  logic [WORD_W-1:0]       r_fifo [2];
  logic                    r_wptr;
  logic                    r_rptr;
  logic [1:0]              r_count;

  logic                    w_start;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_in_ready;
  logic                    w_wr_en;
  logic                    w_last_row;
  logic signed [9:0]       w_rem;
  logic [VL_W-1:0]         w_valid_lanes;
  logic signed [ACC_W-1:0] w_acc;
  logic [WORD_W-1:0]       w_packed;

  assign w_start    = bus.start && (r_state == S_IDLE);
  assign w_in_ready = (r_state == S_RUN) && (r_count != 2'd2) && (r_rows_in != r_m);
  assign w_wr_en    = (r_count != 2'd0);
  assign w_push     = bus.in_valid && w_in_ready;
  assign w_pop      = w_wr_en && bus.wr_gnt;
  assign w_last_row = w_push && (4'(r_rows_in + 4'd1) == r_m);

  assign bus.in_ready = w_in_ready;
  assign bus.wr_en    = w_wr_en;
  assign bus.wr_addr  = r_addr;
  assign bus.wr_data  = r_fifo[r_rptr];
  assign bus.busy     = (r_state != S_IDLE);
  assign bus.done     = (r_state == S_DONE);
  assign o_dbg_state  = r_state;

  // Columns left in this tile; a negative or zero remainder means every lane is padding.
  always_comb begin
    w_rem = $signed({6'd0, bus.n}) - $signed(10'(LANES) * {6'd0, bus.tile});
    if (w_rem[9] || (w_rem == '0)) begin
      w_valid_lanes = '0;
    end else if (w_rem >= $signed(10'(LANES))) begin
      w_valid_lanes = VL_W'(LANES);
    end else begin
      w_valid_lanes = w_rem[VL_W-1:0];
    end
  end

  always_comb begin
    w_packed = '0;
    w_acc    = '0;
    for (int i = 0; i < LANES; i++) begin
      w_acc = bus.in_data[i*ACC_W +: ACC_W];
      if (VL_W'(i) >= r_valid_lanes) begin
        w_packed[i*8 +: 8] = 8'h00;
      end else if ((SAT != 0) && (w_acc > SMAX)) begin
        w_packed[i*8 +: 8] = 8'h7F;
      end else if ((SAT != 0) && (w_acc < SMIN)) begin
        w_packed[i*8 +: 8] = 8'h80;
      end else begin
        w_packed[i*8 +: 8] = w_acc[7:0];
      end
    end
  end

  // RUN leaves on the edge that accepts the m-th row, so in_ready never over-accepts.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_next = S_RUN;
      S_RUN:   if ((r_rows_in == r_m) || w_last_row) w_next = S_DRAIN;
      S_DRAIN: if ((r_count == 2'd0) || ((r_count == 2'd1) && w_pop)) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_m           <= '0;
      r_n_tiles     <= '0;
      r_rows_in     <= '0;
      r_valid_lanes <= '0;
      r_addr        <= '0;
      r_fifo[0]     <= '0;
      r_fifo[1]     <= '0;
      r_wptr        <= 1'b0;
      r_rptr        <= 1'b0;
      r_count       <= '0;
    end else begin
      r_state <= w_next;
      if (w_start) begin
        r_m           <= bus.m;
        r_n_tiles     <= bus.n_tiles;
        r_addr        <= ADDR_W'(bus.tile);
        r_rows_in     <= '0;
        r_valid_lanes <= w_valid_lanes;
      end else if (w_pop) begin
        r_addr <= r_addr + ADDR_W'(r_n_tiles);
      end
      if (w_push) begin
        r_fifo[r_wptr] <= w_packed;
        r_wptr         <= ~r_wptr;
        r_rows_in      <= 4'(r_rows_in + 4'd1);
      end
      if (w_pop) begin
        r_rptr <= ~r_rptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: tb/tb_tpu_out_writer.sv
// Directed bench for tpu_out_writer: single row, lane mask, saturation, backpressure, mid-tile reset, ignored start.
module tb_tpu_out_writer;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] dbg_state;
  logic [1:0] sat_dbg_state;

  tpu_out_writer_if #(.LANES(5), .ACC_W(16), .ADDR_W(8)) bus ();
  tpu_out_writer_if #(.LANES(5), .ACC_W(16), .ADDR_W(8)) sbus ();

  tpu_out_writer #(.LANES(5), .ACC_W(16), .ADDR_W(8), .SAT(0)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave), .o_dbg_state(dbg_state)
  );
  tpu_out_writer #(.LANES(5), .ACC_W(16), .ADDR_W(8), .SAT(1)) dut_sat (
    .clk(clk), .rst_n(rst_n), .bus(sbus.slave), .o_dbg_state(sat_dbg_state)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          done_cnt = 0;
  int          done_cyc = 0;
  int          last_commit_cyc = 0;
  logic [7:0]  got_addr_q[$];
  logic [39:0] got_data_q[$];
  logic [39:0] exp_q[$];
  logic [7:0]  exp_addr_q[$];
  logic [79:0] row_q[$];

  // Commit and done monitor on the main instance.
  always @(posedge clk) begin
    if (bus.wr_en && bus.wr_gnt) begin
      got_addr_q.push_back(bus.wr_addr);
      got_data_q.push_back(bus.wr_data);
      last_commit_cyc = cyc;
    end
    if (rst_n && bus.done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    cyc++;
  end

  function automatic logic [79:0] row5(input logic [15:0] a0, a1, a2, a3, a4);
    return {a4, a3, a2, a1, a0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    got_addr_q.delete();
    got_data_q.delete();
    exp_q.delete();
    exp_addr_q.delete();
    row_q.delete();
    done_cnt = 0;
  endtask

  task automatic do_start(input logic [3:0] mm, nn, tt, nt);
    bus.start = 1'b1; bus.m = mm; bus.n = nn; bus.tile = tt; bus.n_tiles = nt;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic feed(input int max_cyc, output int used, output bit ok);
    bit acc;
    used = 0;
    while (row_q.size() > 0 && used < max_cyc) begin
      bus.in_valid = 1'b1;
      bus.in_data  = row_q[0];
      acc = bus.in_ready;
      tick();
      if (acc) void'(row_q.pop_front());
      used++;
    end
    bus.in_valid = 1'b0;
    ok = (row_q.size() == 0);
  endtask

  task automatic wait_idle(input int max_cyc, output bit ok);
    for (int i = 0; i < max_cyc; i++) begin
      if (!bus.busy) break;
      tick();
    end
    ok = !bus.busy;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    checks++; if (bus.wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b want 0", bus.wr_en); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.done); end
    checks++; if (bus.wr_addr !== 8'h00) begin errors++; $display("FAIL reset_wr_addr: got %h want 00", bus.wr_addr); end
    checks++; if (bus.wr_data !== 40'h0) begin errors++; $display("FAIL reset_wr_data: got %h want 0", bus.wr_data); end
    rst_n = 1'b1;
    tick();
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
  endtask

  task automatic test_single();
    int used; bit ok;
    clear_mon();
    bus.wr_gnt = 1'b1;
    do_start(4'd1, 4'd5, 4'd0, 4'd1);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", bus.busy); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL single_ready: got %b want 1", bus.in_ready); end
    row_q.push_back(row5(16'd1, 16'd2, 16'd3, 16'd4, 16'd5));
    feed(10, used, ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_feed: got timeout want accepted"); end
    wait_idle(20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_idle: got busy want idle"); end
    checks++; if (got_data_q.size() != 1) begin errors++; $display("FAIL single_nwrites: got %0d want 1", got_data_q.size()); end
    if (got_data_q.size() == 1) begin
      checks++; if (got_addr_q[0] !== 8'h00) begin errors++; $display("FAIL single_addr: got %h want 00", got_addr_q[0]); end
      checks++; if (got_data_q[0] !== 40'h0504030201) begin errors++; $display("FAIL single_data: got %h want 0504030201", got_data_q[0]); end
    end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL single_done_cnt: got %0d want 1", done_cnt); end
    checks++; if (done_cyc - last_commit_cyc != 1) begin errors++; $display("FAIL single_done_lat: got %0d want 1", done_cyc - last_commit_cyc); end
  endtask

  task automatic test_mask();
    int used; bit ok;
    clear_mon();
    bus.wr_gnt = 1'b1;
    do_start(4'd3, 4'd7, 4'd1, 4'd2);
    for (int i = 0; i < 3; i++) begin
      row_q.push_back(row5(16'h0011, 16'h0011, 16'h0011, 16'h0011, 16'h0011));
      exp_q.push_back(40'h0000001111);
      exp_addr_q.push_back(8'(1 + 2 * i));
    end
    feed(10, used, ok);
    checks++; if (used != 3) begin errors++; $display("FAIL mask_throughput: got %0d cycles want 3", used); end
    wait_idle(20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL mask_idle: got busy want idle"); end
    checks++; if (got_data_q.size() != exp_q.size()) begin errors++; $display("FAIL mask_nwrites: got %0d want %0d", got_data_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_data_q.size(); i++) begin
      checks++; if (got_addr_q[i] !== exp_addr_q[i]) begin errors++; $display("FAIL mask_addr%0d: got %h want %h", i, got_addr_q[i], exp_addr_q[i]); end
      checks++; if (got_data_q[i] !== exp_q[i]) begin errors++; $display("FAIL mask_data%0d: got %h want %h", i, got_data_q[i], exp_q[i]); end
    end
    checks++; if (done_cyc - last_commit_cyc != 1) begin errors++; $display("FAIL mask_done_lat: got %0d want 1", done_cyc - last_commit_cyc); end
  endtask

  task automatic test_sat();
    bit ok;
    logic [79:0] r;
    clear_mon();
    r = row5(16'd300, 16'hFED4, 16'd127, 16'hFF80, 16'd0);
    bus.wr_gnt = 1'b0; sbus.wr_gnt = 1'b0;
    bus.start = 1'b1; bus.m = 4'd1; bus.n = 4'd5; bus.tile = 4'd0; bus.n_tiles = 4'd1;
    sbus.start = 1'b1; sbus.m = 4'd1; sbus.n = 4'd5; sbus.tile = 4'd0; sbus.n_tiles = 4'd1;
    tick();
    bus.start = 1'b0; sbus.start = 1'b0;
    checks++; if (sbus.in_ready !== 1'b1) begin errors++; $display("FAIL sat_ready: got %b want 1", sbus.in_ready); end
    bus.in_valid = 1'b1; bus.in_data = r;
    sbus.in_valid = 1'b1; sbus.in_data = r;
    tick();
    bus.in_valid = 1'b0; sbus.in_valid = 1'b0;
    checks++; if (sbus.wr_en !== 1'b1) begin errors++; $display("FAIL sat_wr_en: got %b want 1", sbus.wr_en); end
    checks++; if (sbus.wr_data !== 40'h00807F807F) begin errors++; $display("FAIL sat_data: got %h want 00807F807F", sbus.wr_data); end
    checks++; if (bus.wr_data !== 40'h00807FD42C) begin errors++; $display("FAIL nosat_data: got %h want 00807FD42C", bus.wr_data); end
    bus.wr_gnt = 1'b1; sbus.wr_gnt = 1'b1;
    wait_idle(20, ok);
    repeat (2) tick();
    checks++; if (sbus.busy !== 1'b0) begin errors++; $display("FAIL sat_idle: got %b want 0", sbus.busy); end
    checks++; if (got_data_q.size() != 1) begin errors++; $display("FAIL nosat_nwrites: got %0d want 1", got_data_q.size()); end
  endtask

  task automatic test_backpressure();
    int used; bit ok; bit acc;
    clear_mon();
    bus.wr_gnt = 1'b0;
    do_start(4'd3, 4'd5, 4'd0, 4'd1);
    row_q.push_back(row5(16'h000A, 16'h000B, 16'h000C, 16'h000D, 16'h000E));
    row_q.push_back(row5(16'h0110, 16'h0220, 16'h0330, 16'h0440, 16'h0550));
    row_q.push_back(row5(16'hFFFF, 16'h8000, 16'h007F, 16'h0080, 16'h1234));
    exp_q.push_back(40'h0E0D0C0B0A); exp_addr_q.push_back(8'd0);
    exp_q.push_back(40'h5040302010); exp_addr_q.push_back(8'd1);
    exp_q.push_back(40'h34807F00FF); exp_addr_q.push_back(8'd2);
    for (int c = 0; c < 4; c++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = row_q[0];
      acc = bus.in_ready;
      tick();
      if (acc) void'(row_q.pop_front());
      checks++; if (bus.wr_addr !== 8'd0) begin errors++; $display("FAIL bp_addr_hold%0d: got %h want 00", c, bus.wr_addr); end
      checks++; if (bus.wr_data !== 40'h0E0D0C0B0A) begin errors++; $display("FAIL bp_data_hold%0d: got %h want 0E0D0C0B0A", c, bus.wr_data); end
    end
    checks++; if (row_q.size() != 1) begin errors++; $display("FAIL bp_accepted: got %0d want 2", 3 - row_q.size()); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_full: got %b want 0", bus.in_ready); end
    checks++; if (got_data_q.size() != 0) begin errors++; $display("FAIL bp_no_write: got %0d want 0", got_data_q.size()); end
    bus.wr_gnt = 1'b1;
    feed(10, used, ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_feed: got timeout want accepted"); end
    wait_idle(20, ok);
    checks++; if (got_data_q.size() != exp_q.size()) begin errors++; $display("FAIL bp_nwrites: got %0d want %0d", got_data_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_data_q.size(); i++) begin
      checks++; if (got_addr_q[i] !== exp_addr_q[i]) begin errors++; $display("FAIL bp_addr%0d: got %h want %h", i, got_addr_q[i], exp_addr_q[i]); end
      checks++; if (got_data_q[i] !== exp_q[i]) begin errors++; $display("FAIL bp_data%0d: got %h want %h", i, got_data_q[i], exp_q[i]); end
    end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL bp_done_cnt: got %0d want 1", done_cnt); end
  endtask

  task automatic test_reset_mid();
    int used; bit ok;
    clear_mon();
    bus.wr_gnt = 1'b0;
    do_start(4'd3, 4'd5, 4'd0, 4'd1);
    row_q.push_back(row5(16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005));
    row_q.push_back(row5(16'h0006, 16'h0007, 16'h0008, 16'h0009, 16'h000A));
    feed(4, used, ok);
    checks++; if (bus.wr_en !== 1'b1 || bus.in_ready !== 1'b0) begin errors++; $display("FAIL rm_full: got wr_en=%b in_ready=%b want 1 0", bus.wr_en, bus.in_ready); end
    #2 rst_n = 1'b0;
    bus.wr_gnt = 1'b1;
    #1;
    checks++; if (bus.wr_en !== 1'b0) begin errors++; $display("FAIL rm_wr_en: got %b want 0", bus.wr_en); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rm_busy: got %b want 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL rm_done: got %b want 0", bus.done); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rm_in_ready: got %b want 0", bus.in_ready); end
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    checks++; if (got_data_q.size() != 0) begin errors++; $display("FAIL rm_stale_write: got %0d want 0", got_data_q.size()); end
    do_start(4'd1, 4'd15, 4'd2, 4'd3);
    row_q.push_back(row5(16'h00AA, 16'h00BB, 16'h00CC, 16'h00DD, 16'h00EE));
    feed(10, used, ok);
    wait_idle(20, ok);
    checks++; if (got_data_q.size() != 1) begin errors++; $display("FAIL rm_nwrites: got %0d want 1", got_data_q.size()); end
    if (got_data_q.size() == 1) begin
      checks++; if (got_addr_q[0] !== 8'd2) begin errors++; $display("FAIL rm_addr: got %h want 02", got_addr_q[0]); end
      checks++; if (got_data_q[0] !== 40'hEEDDCCBBAA) begin errors++; $display("FAIL rm_data: got %h want EEDDCCBBAA", got_data_q[0]); end
    end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL rm_done_cnt: got %0d want 1", done_cnt); end
  endtask

  task automatic test_start_ignored();
    int used; bit ok;
    clear_mon();
    bus.wr_gnt = 1'b1;
    do_start(4'd2, 4'd5, 4'd0, 4'd1);
    exp_q.push_back(40'h0A08060402); exp_addr_q.push_back(8'd0);
    exp_q.push_back(40'hF5F4F3F2F1); exp_addr_q.push_back(8'd1);
    row_q.push_back(row5(16'h0102, 16'h0304, 16'h0506, 16'h0708, 16'h090A));
    feed(4, used, ok);
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL si_ready: got %b want 1", bus.in_ready); end
    bus.start = 1'b1; bus.m = 4'd5; bus.n = 4'd9; bus.tile = 4'd3; bus.n_tiles = 4'd4;
    bus.in_valid = 1'b1;
    bus.in_data = row5(16'h00F1, 16'h00F2, 16'h00F3, 16'h00F4, 16'h00F5);
    tick();
    bus.start = 1'b0; bus.in_valid = 1'b0;
    wait_idle(20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL si_idle: got busy want idle"); end
    checks++; if (got_data_q.size() != exp_q.size()) begin errors++; $display("FAIL si_nwrites: got %0d want %0d", got_data_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_data_q.size(); i++) begin
      checks++; if (got_addr_q[i] !== exp_addr_q[i]) begin errors++; $display("FAIL si_addr%0d: got %h want %h", i, got_addr_q[i], exp_addr_q[i]); end
      checks++; if (got_data_q[i] !== exp_q[i]) begin errors++; $display("FAIL si_data%0d: got %h want %h", i, got_data_q[i], exp_q[i]); end
    end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL si_done_cnt: got %0d want 1", done_cnt); end
  endtask

  initial begin
    bus.start = 1'b0; bus.m = '0; bus.n = '0; bus.tile = '0; bus.n_tiles = '0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.wr_gnt = 1'b0;
    sbus.start = 1'b0; sbus.m = '0; sbus.n = '0; sbus.tile = '0; sbus.n_tiles = '0;
    sbus.in_valid = 1'b0; sbus.in_data = '0; sbus.wr_gnt = 1'b0;
    test_reset();
    test_single();
    test_mask();
    test_sat();
    test_backpressure();
    test_reset_mid();
    test_start_ignored();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1, "global timeout");
  end
endmodule
